// File: rtl/doorbell_pkg.sv
// Shared types and constants for the doorbell chime path.
// Used by the sequencer and the downstream chime mux.
package doorbell_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DING = 2'd1,
    GAP  = 2'd2,
    DONG = 2'd3
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  localparam int DEF_DEBOUNCE = 4;
  localparam int DEF_DING     = 8;
  localparam int DEF_GAP      = 2;
  localparam int DEF_DONG     = 12;
  localparam int DEF_CNT_W    = 16;

  function automatic logic [7:0] sat_inc8(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/doorbell_sequencer_debouncer.sv
// Button synchroniser, debounce filter and rising-edge
// press pulse.
module button_debouncer
  import doorbell_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic press
);

  localparam logic [CNT_W-1:0] DB_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             level;
  logic             level_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      s1      <= button;
      s2      <= s1;
      level_q <= level;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign press = level & ~level_q;

endmodule

// File: rtl/doorbell_sequencer.sv
// Ding-gap-dong sequencer driving the chime mux select
// and speaker gate, with one-deep press queueing.
module doorbell_sequencer
  import doorbell_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter int DING_CYCLES     = DEF_DING,
  parameter int GAP_CYCLES      = DEF_GAP,
  parameter int DONG_CYCLES     = DEF_DONG,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button,
  output logic       sel,
  output logic       play,
  output logic       busy,
  output logic       done,
  output logic       pending,
  output logic [7:0] press_count
);

  localparam logic [CNT_W-1:0] DING_LAST =
    CNT_W'(DING_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] DONG_LAST =
    CNT_W'(DONG_CYCLES - 1);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             pending_n;
  logic             done_n;
  logic [7:0]       press_count_n;
  logic             press;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db (
    .clk   (clk),
    .rst_n (rst_n),
    .button(button),
    .press (press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      pending     <= 1'b0;
      done        <= 1'b0;
      press_count <= 8'd0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      pending     <= pending_n;
      done        <= done_n;
      press_count <= press_count_n;
    end
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt + CNT_W'(1);
    pending_n     = pending;
    done_n        = 1'b0;
    press_count_n = press_count;
    if (press && state != IDLE && !pending)
      pending_n = 1'b1;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        // a press caught on DONG's last cycle lands here
        if (press || pending) begin
          state_n       = DING;
          pending_n     = 1'b0;
          press_count_n = sat_inc8(press_count);
        end
      end
      DING: begin
        if (cnt == DING_LAST) begin
          cnt_n = '0;
          if (GAP_CYCLES == 0) state_n = DONG;
          else                 state_n = GAP;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n   = '0;
          state_n = DONG;
        end
      end
      DONG: begin
        if (cnt == DONG_LAST) begin
          cnt_n  = '0;
          done_n = 1'b1;
          if (pending) begin
            state_n       = DING;
            pending_n     = 1'b0;
            press_count_n = sat_inc8(press_count);
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign sel  = (state == DONG) ? SEL_B : SEL_A;
  assign play = (state == DING) || (state == DONG);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_doorbell_sequencer.sv
// Directed bench for doorbell_sequencer: default build plus
// a zero-gap build sharing the same button and reset.
module tb_doorbell_sequencer;

  logic       clk;
  logic       rst_n;
  logic       button;
  logic       sel, play, busy, done, pending;
  logic [7:0] press_count;
  logic       sel0, play0, busy0, done0, pending0;
  logic [7:0] press_count0;

  int errors = 0;
  int checks = 0;

  doorbell_sequencer u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .button     (button),
    .sel        (sel),
    .play       (play),
    .busy       (busy),
    .done       (done),
    .pending    (pending),
    .press_count(press_count)
  );

  doorbell_sequencer #(.GAP_CYCLES(0)) u_dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .button     (button),
    .sel        (sel0),
    .play       (play0),
    .busy       (busy0),
    .done       (done0),
    .pending    (pending0),
    .press_count(press_count0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs,
                      input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b",
             tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag,
                      input logic [7:0] obs,
                      input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  function automatic logic qbtn(input int e);
    return (e >= 1 && e <= 4) || (e >= 13 && e <= 16) ||
           (e >= 21 && e <= 24);
  endfunction

  initial begin
    rst_n  = 1'b0;
    button = 1'b0;

    // reset held with a bouncing button
    for (int i = 0; i < 8; i++) begin
      #7 button = ~button;
      chk1("rst play", play, 1'b0);
      chk1("rst busy", busy, 1'b0);
    end
    button = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk8("idle outs", 8'({sel, play, busy, done, pending}),
           8'd0);
      chk8("idle outs0",
           8'({sel0, play0, busy0, done0, pending0}), 8'd0);
    end
    chk8("idle count", press_count, 8'd0);

    // glitch: 3 cycles high
    button = 1'b1;
    tick(); tick(); tick();
    button = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk1($sformatf("glitch busy %0d", i), busy, 1'b0);
      chk1($sformatf("glitch busy0 %0d", i), busy0, 1'b0);
    end
    chk8("glitch count", press_count, 8'd0);
    chk8("glitch count0", press_count0, 8'd0);

    // single clean press, 10 cycles high
    button = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      tick();
      chk1($sformatf("single play e%0d", e), play,
           (e >= 7 && e <= 14) || (e >= 17 && e <= 28));
      chk1($sformatf("single sel e%0d", e), sel,
           e >= 17 && e <= 28);
      chk1($sformatf("single busy e%0d", e), busy,
           e >= 7 && e <= 28);
      chk1($sformatf("single done e%0d", e), done, e == 29);
      chk1($sformatf("nogap play e%0d", e), play0,
           e >= 7 && e <= 26);
      chk1($sformatf("nogap sel e%0d", e), sel0,
           e >= 15 && e <= 26);
      chk1($sformatf("nogap done e%0d", e), done0, e == 27);
      if (e == 10) button = 1'b0;
    end
    chk8("single count", press_count, 8'd1);
    chk8("nogap count", press_count0, 8'd1);

    // queued press during DONG, third press dropped
    button = 1'b1;
    for (int e = 1; e <= 52; e++) begin
      tick();
      chk1($sformatf("queue pend e%0d", e), pending,
           e >= 19 && e <= 28);
      chk1($sformatf("queue done e%0d", e), done,
           e == 29 || e == 51);
      chk1($sformatf("queue play e%0d", e), play,
           (e >= 7 && e <= 14) || (e >= 17 && e <= 36) ||
           (e >= 39 && e <= 50));
      chk1($sformatf("queue sel e%0d", e), sel,
           (e >= 17 && e <= 28) || (e >= 39 && e <= 50));
      chk8($sformatf("queue count e%0d", e), press_count,
           (e < 7) ? 8'd1 : (e < 29) ? 8'd2 : 8'd3);
      button = qbtn(e + 1);
    end
    chk1("queue idle busy", busy, 1'b0);

    // async reset mid-DONG with a pending press
    button = 1'b1;
    for (int e = 1; e <= 21; e++) begin
      tick();
      button = (e + 1 <= 4) || (e + 1 >= 13 && e + 1 <= 16);
    end
    chk1("pre-rst sel", sel, 1'b1);
    chk1("pre-rst pending", pending, 1'b1);
    chk8("pre-rst count", press_count, 8'd4);
    #2 rst_n = 1'b0;
    #1;
    chk1("arst sel", sel, 1'b0);
    chk1("arst play", play, 1'b0);
    chk1("arst busy", busy, 1'b0);
    chk1("arst pending", pending, 1'b0);
    chk8("arst count", press_count, 8'd0);
    @(negedge clk);
    button = 1'b0;
    rst_n  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1($sformatf("post-rst busy %0d", i), busy, 1'b0);
    end
    chk8("post-rst count", press_count, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
